// File: rtl/zet_prefix_fetch.sv
// zet_prefix_fetch: strips LOCK/REP/REPNZ/segment prefixes from the byte stream and presents the opcode with accumulated prefix state (clk, rst_n, flush, byte_i/byte_valid/byte_ready in; op_valid/op_ready, opcode, prefix, lock, seg_ovr, seg, pfx_len, pfx_err out)
module zet_prefix_fetch #(
  parameter int MAX_PREFIX = 14,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [7:0]       byte_i,
  input  logic             byte_valid,
  output logic             byte_ready,
  output logic             op_valid,
  input  logic             op_ready,
  output logic [7:0]       opcode,
  output logic [1:0]       prefix,
  output logic             lock,
  output logic             seg_ovr,
  output logic [1:0]       seg,
  output logic [CNT_W-1:0] pfx_len,
  output logic             pfx_err
);
  typedef enum logic {FETCH, HOLD} state_t;
  state_t state, state_d;
  logic accept, is_pfx, is_rep, is_seg, is_lock, clear;
  always_comb begin
    is_rep = byte_i[7:1] == 7'b1111001;
    is_lock = byte_i == 8'hf0;
    is_seg = byte_i[7:5] == 3'b001 && byte_i[2:0] == 3'b110;
    is_pfx = is_rep || is_lock || is_seg;
    byte_ready = state == FETCH && !flush;
    op_valid = state == HOLD;
    accept = byte_valid && byte_ready;
    clear = flush || (state == HOLD && op_ready);
    state_d = flush ? FETCH :
              (state == FETCH && accept && !is_pfx) ? HOLD :
              (state == HOLD && op_ready) ? FETCH : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= FETCH;
    else state <= state_d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      opcode <= '0;
      prefix <= '0;
      lock <= 1'b0;
      seg_ovr <= 1'b0;
      seg <= '0;
      pfx_len <= '0;
      pfx_err <= 1'b0;
    end else if (clear) begin
      prefix <= '0;
      lock <= 1'b0;
      seg_ovr <= 1'b0;
      seg <= '0;
      pfx_len <= '0;
      pfx_err <= 1'b0;
    end else if (accept && is_pfx) begin
      if (is_rep) prefix <= {1'b1, byte_i[0]};
      if (is_seg) begin
        seg_ovr <= 1'b1;
        seg <= byte_i[4:3];
      end
      if (is_lock) lock <= 1'b1;
      if (pfx_len == CNT_W'(MAX_PREFIX)) pfx_err <= 1'b1;
      else pfx_len <= pfx_len + 1'b1;
    end else if (accept) opcode <= byte_i;
endmodule

// File: tb/tb_zet_prefix_fetch.sv
// tb_zet_prefix_fetch: table-driven and directed checks of zet_prefix_fetch
module tb_zet_prefix_fetch;
  logic clk, rst_n, flush, byte_valid, byte_ready, op_valid, op_ready;
  logic [7:0] byte_i, opcode;
  logic [1:0] prefix, seg;
  logic lock, seg_ovr, pfx_err;
  logic [3:0] pfx_len;
  logic [20:0] act;
  int vecs = 0, errs = 0;
  typedef struct {
    logic fl, bv, orr;
    logic [7:0] b;
    logic [20:0] exp;
  } vec_t;
  vec_t vq[$];
  zet_prefix_fetch #(.MAX_PREFIX(14), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .byte_i(byte_i), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .op_valid(op_valid), .op_ready(op_ready), .opcode(opcode),
    .prefix(prefix), .lock(lock), .seg_ovr(seg_ovr), .seg(seg), .pfx_len(pfx_len), .pfx_err(pfx_err)
  );
  assign act = {byte_ready, op_valid, opcode, prefix, lock, seg_ovr, seg, pfx_len, pfx_err};
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic v(input logic fl, bv, input logic [7:0] b, input logic orr,
                   input logic br, ov, input logic [7:0] opc, input logic [1:0] pr,
                   input logic lk, so, input logic [1:0] sg, input logic [3:0] len, input logic er);
    vq.push_back('{fl: fl, bv: bv, orr: orr, b: b, exp: {br, ov, opc, pr, lk, so, sg, len, er}});
  endtask
  task automatic chk(input string n, input logic [31:0] a, e);
    vecs++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  task automatic drive(input logic fl, bv, input logic [7:0] b, input logic orr);
    flush = fl;
    byte_valid = bv;
    byte_i = b;
    op_ready = orr;
  endtask
  task automatic step(input logic fl, bv, input logic [7:0] b, input logic orr);
    @(negedge clk);
    drive(fl, bv, b, orr);
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst_n = 1'b0;
    drive(0, 0, 8'h00, 0);
    v(0,0,8'h00,1, 1,0,8'h00,2'b00,0,0,2'd0,4'd0,0);
    v(0,1,8'hf3,1, 1,0,8'h00,2'b00,0,0,2'd0,4'd0,0);
    v(0,1,8'ha4,1, 1,0,8'h00,2'b11,0,0,2'd0,4'd1,0);
    v(0,0,8'h00,1, 0,1,8'ha4,2'b11,0,0,2'd0,4'd1,0);
    v(0,0,8'h00,1, 1,0,8'ha4,2'b00,0,0,2'd0,4'd0,0);
    v(0,1,8'hf3,1, 1,0,8'ha4,2'b00,0,0,2'd0,4'd0,0);
    v(0,0,8'h00,1, 1,0,8'ha4,2'b11,0,0,2'd0,4'd1,0);
    v(0,1,8'hf2,1, 1,0,8'ha4,2'b11,0,0,2'd0,4'd1,0);
    v(0,0,8'h00,1, 1,0,8'ha4,2'b10,0,0,2'd0,4'd2,0);
    v(0,1,8'h2e,1, 1,0,8'ha4,2'b10,0,0,2'd0,4'd2,0);
    v(0,1,8'hf0,1, 1,0,8'ha4,2'b10,0,1,2'd1,4'd3,0);
    v(0,0,8'h00,1, 1,0,8'ha4,2'b10,1,1,2'd1,4'd4,0);
    v(0,1,8'ha6,1, 1,0,8'ha4,2'b10,1,1,2'd1,4'd4,0);
    v(0,0,8'h00,1, 0,1,8'ha6,2'b10,1,1,2'd1,4'd4,0);
    v(0,1,8'h90,0, 1,0,8'ha6,2'b00,0,0,2'd0,4'd0,0);
    for (int i = 0; i < 5; i++) v(0,1,8'h26,0, 0,1,8'h90,2'b00,0,0,2'd0,4'd0,0);
    v(0,1,8'h26,1, 0,1,8'h90,2'b00,0,0,2'd0,4'd0,0);
    v(0,1,8'h26,0, 1,0,8'h90,2'b00,0,0,2'd0,4'd0,0);
    v(0,1,8'hc3,0, 1,0,8'h90,2'b00,0,1,2'd0,4'd1,0);
    v(0,0,8'h00,1, 0,1,8'hc3,2'b00,0,1,2'd0,4'd1,0);
    v(0,0,8'h00,1, 1,0,8'hc3,2'b00,0,0,2'd0,4'd0,0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    foreach (vq[i]) begin
      @(negedge clk);
      drive(vq[i].fl, vq[i].bv, vq[i].b, vq[i].orr);
      #1;
      chk($sformatf("vec%0d", i), 32'(act), 32'(vq[i].exp));
    end
    step(0, 1, 8'hf3, 0);
    step(0, 1, 8'h3e, 0);
    @(negedge clk);
    drive(1, 1, 8'ha5, 0);
    #1;
    chk("flush_br", 32'(byte_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("flush_clr", 32'({op_valid, prefix, seg_ovr, pfx_len}), 32'd0);
    step(0, 1, 8'haa, 0);
    chk("post_flush_op", 32'({op_valid, opcode, prefix, seg_ovr, pfx_len}), 32'({1'b1, 8'haa, 7'd0}));
    step(0, 0, 8'h00, 1);
    step(0, 1, 8'hf3, 0);
    step(0, 1, 8'hab, 0);
    chk("hold_ab", 32'({op_valid, opcode, prefix, pfx_len}), 32'({1'b1, 8'hab, 2'b11, 4'd1}));
    step(1, 0, 8'h00, 1);
    chk("flush_hold", 32'({op_valid, prefix, lock, seg_ovr, seg, pfx_len, pfx_err}), 32'd0);
    for (int i = 0; i < 14; i++) step(0, 1, 8'h26, 0);
    chk("pfx14", 32'({pfx_len, pfx_err, seg_ovr}), 32'({4'd14, 1'b0, 1'b1}));
    step(0, 1, 8'h26, 0);
    chk("pfx15", 32'({pfx_len, pfx_err}), 32'({4'd14, 1'b1}));
    step(0, 1, 8'hac, 0);
    chk("pfx_err_hold", 32'({op_valid, opcode, pfx_len, pfx_err}), 32'({1'b1, 8'hac, 4'd14, 1'b1}));
    step(0, 0, 8'h00, 1);
    chk("pfx_err_clr", 32'({op_valid, pfx_len, pfx_err, seg_ovr}), 32'd0);
    step(0, 1, 8'hf0, 0);
    step(0, 1, 8'h5a, 0);
    chk("pre_rst", 32'({op_valid, opcode, lock, pfx_len}), 32'({1'b1, 8'h5a, 1'b1, 4'd1}));
    @(negedge clk);
    drive(0, 0, 8'h00, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst", 32'(act), 32'(21'h100000));
    @(negedge clk);
    rst_n = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/zet_prefix_fetch.md
Name: zet_prefix_fetch

Overview:
- Instruction-byte front end of the fetch FSM. Consumes the raw instruction byte stream and strips and accumulates x86 prefix bytes: LOCK, REP/REPZ, REPNZ and segment overrides.
- Presents the first non-prefix byte together with the accumulated prefix state to the downstream fetch/decode logic. The REP-continuation helper uses its `prefix[1:0]` and `opcode[7:1]` directly.
- Also reports the prefix length, so the sequencer can rewind IP when a REP instruction is interrupted.

Parameters:
- MAX_PREFIX, 14, max prefix bytes before error (14 prefixes plus 1 opcode = 15-byte x86 limit).
- CNT_W, 4, width of `pfx_len`; must hold MAX_PREFIX.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous abort (jump/interrupt/exception); highest priority.
- byte_i  in  8  instruction byte from the prefetch queue.
- byte_valid  in  1  `byte_i` is valid.
- byte_ready  out  1  stage accepts `byte_i` this cycle.
- op_valid  out  1  opcode plus prefix state presented.
- op_ready  in  1  downstream consumes the presented opcode.
- opcode  out  8  first non-prefix byte.
- prefix  out  2  bit1 = a REP-class prefix is present; bit0 = 1 for F3 (REP/REPZ), 0 for F2 (REPNZ).
- lock  out  1  F0 prefix seen.
- seg_ovr  out  1  segment override present.
- seg  out  2  override segment: ES=0, CS=1, SS=2, DS=3.
- pfx_len  out  CNT_W  number of prefix bytes consumed for this instruction.
- pfx_err  out  1  more than MAX_PREFIX prefixes were seen.

Behaviour:
- Reset (`rst_n` low, async): state = FETCH. All registers clear: `opcode`=00, `prefix`=00, `lock`=0, `seg_ovr`=0, `seg`=0, `pfx_len`=0, `pfx_err`=0, `op_valid`=0.
- State machine, 2 states:
  - FETCH: `byte_ready` = !`flush`; `op_valid` = 0.
  - HOLD: `byte_ready` = 0; `op_valid` = 1.
- Accept = `byte_valid` & `byte_ready` in FETCH.
- Prefix codes: F0 lock; F2 repnz; F3 rep/repz; 26/2E/36/3E seg 0/1/2/3.
- Accepted prefix byte:
  - F2/F3: `prefix[1]`=1; `prefix[0]` = byte[0]. The last REP-class prefix wins.
  - Segment prefix: `seg_ovr`=1; `seg` = code. The last segment prefix wins.
  - F0: `lock`=1.
  - `pfx_len` increments, saturating at MAX_PREFIX.
  - If a prefix arrives while `pfx_len` == MAX_PREFIX: `pfx_err`=1 (sticky until the opcode is consumed or flushed) and `pfx_len` holds. The prefix's effect is still applied.
  - State stays FETCH.
- Accepted non-prefix byte: `opcode` <= byte; state -> HOLD.
  - `op_valid` rises the cycle after the accepting edge (1-cycle latency).
  - Prefix outputs are stable for the whole HOLD period.
- HOLD with `op_ready`=1 at an edge:
  - state -> FETCH.
  - `prefix`/`lock`/`seg_ovr`/`seg`/`pfx_len`/`pfx_err` clear.
  - `opcode` holds its old value (don't-care while `op_valid`=0).
- HOLD with `op_ready`=0: all outputs hold indefinitely. A stalled downstream never loses an opcode.
- No same-cycle bypass: `byte_ready` is 0 in HOLD, so the earliest next accept is the cycle after consumption. Throughput is one opcode per 2 cycles plus one cycle per prefix.
- `flush`=1 at an edge, any state:
  - State -> FETCH; all prefix fields clear; `op_valid` -> 0.
  - Any byte presented that cycle is not accepted (`byte_ready` is low).
  - Overrides a simultaneous `op_ready`.
- `byte_valid`=0 in FETCH: no change. Prefixes accumulated so far are retained across bubbles.
- `rst_n` asserted mid-instruction: immediate async clear to the reset state.

Test Plan:
- Reset, then bytes F3,A4 back-to-back with `op_ready`=1 -> `op_valid` high for 1 cycle with `opcode`=A4, `prefix`=11, `pfx_len`=1; next cycle all fields are 0.
- Bytes F3,F2,2E,F0,A6 with gaps between bytes -> `opcode`=A6, `prefix`=10 (last REP wins), `seg_ovr`=1, `seg`=1, `lock`=1, `pfx_len`=4.
- Byte 90, `op_ready` held 0 for 5 cycles while `byte_valid`=1 with byte 26 -> `byte_ready`=0 throughout; `opcode` stays 90 and `seg_ovr`=0; byte 26 is accepted only after the `op_ready` edge.
- 15 × 26 then AC -> `pfx_err`=1, `pfx_len`=14, `opcode`=AC; `pfx_err` clears after consumption.
- F3,3E then `flush` with byte A5 presented -> A5 not accepted; next opcode AA (no prefixes) shows `prefix`=00, `seg_ovr`=0, `pfx_len`=0. `flush` asserted during HOLD with `op_ready`=1 -> `op_valid` drops and fields clear.
- Assert `rst_n` low asynchronously mid-HOLD -> `op_valid`=0 and all outputs 0 immediately, without waiting for a clock edge.
